// File: rtl/dm_arb_pkg.sv
// Shared definitions for the DM read-port arbiter: requester ids, state encoding, id helpers.
package dm_arb_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_CPU = 2'd0;
  localparam logic [1:0] REQ_LDM = 2'd1;
  localparam logic [1:0] REQ_ACC = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Id increment with wrap 2 -> 0.
  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == REQ_ACC) ? REQ_CPU : id + 2'd1;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] id);
    return 3'b001 << id;
  endfunction

endpackage

// File: rtl/dm_read_arbiter_rr_pick3.sv
// Combinational round-robin picker: first set bit of req searching upward from rr, wrapping 2 -> 0.
module rr_pick3
  import dm_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] rr,
  output logic       valid,
  output logic [1:0] id
);

  logic [1:0] c0, c1, c2;

  always_comb begin
    c0    = rr;
    c1    = next_id(rr);
    c2    = next_id(c1);
    valid = |req;
    if (req[c0])      id = c0;
    else if (req[c1]) id = c1;
    else              id = c2;
  end

endmodule

// File: rtl/dm_read_arbiter.sv
// Round-robin arbiter with burst locking for the single DM read port; 1-cycle issue-to-data latency.
// Optional burst timeout under `DMARB_TIMEOUT_EN caps locked bursts at MAX_BURST beats when others wait.
module dm_read_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         DMaddr,
  input  logic [DATA_W-1:0]         DModata,
  output logic [DATA_W-1:0]         rdata,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic                      busy
);

  arb_state_t  state;
  logic [1:0]  owner;
  logic [1:0]  rr;
  logic        tag_v;
  logic [1:0]  tag_id;

  logic [ADDR_W-1:0] addr_sel [NUM_REQ];
  logic              own_req;
  logic              own_locked;
  logic              force_rel;
  logic              hold;
  logic [2:0]        excl;
  logic              pick_v;
  logic [1:0]        pick_id;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign addr_sel[i] = addr[i*ADDR_W +: ADDR_W];
  end

  // A beat is only issued while the owner still requests.
  assign own_req    = (state == OWN) && req[owner];
  assign own_locked = own_req && lock[owner];

`ifdef DMARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] burst_cnt;

  // burst_cnt counts locked beats already completed; the current beat is number burst_cnt+1.
  assign force_rel = own_locked && (burst_cnt == CW'(MAX_BURST - 1)) &&
                     (|(req & ~onehot3(owner)));
  assign excl      = force_rel ? onehot3(owner) : 3'b000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (own_locked && !force_rel) begin
      if (burst_cnt != CW'(MAX_BURST - 1)) burst_cnt <= burst_cnt + 1'b1;
    end else begin
      burst_cnt <= '0;
    end
  end
`else
  logic unused_max_burst;
  assign unused_max_burst = (MAX_BURST > 0);
  assign force_rel        = 1'b0;
  assign excl             = 3'b000;
`endif

  assign hold = own_locked && !force_rel;

  rr_pick3 u_pick (
    .req   (req & ~excl),
    .rr    (rr),
    .valid (pick_v),
    .id    (pick_id)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= REQ_CPU;
      rr     <= REQ_CPU;
      gnt    <= '0;
      DMaddr <= '0;
      tag_v  <= 1'b0;
      tag_id <= REQ_CPU;
    end else begin
      tag_v  <= own_req;
      tag_id <= owner;
      if (hold) begin
        DMaddr <= addr_sel[owner];
      end else if (pick_v) begin
        state  <= OWN;
        owner  <= pick_id;
        gnt    <= onehot3(pick_id);
        DMaddr <= addr_sel[pick_id];
        rr     <= next_id(pick_id);
      end else begin
        state  <= IDLE;
        gnt    <= '0;
      end
    end
  end

  assign rdata  = DModata;
  assign rvalid = tag_v ? onehot3(tag_id) : 3'b000;
  assign busy   = (|gnt) || tag_v;

endmodule
